// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the I2C write master: FSM states, the four
// SCL quarter-phase codes and the R/W bit value used in the address byte.
package i2c_master_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6
  } state_t;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_clk_phase_gen.sv
// Splits each SCL period of DIV clk cycles into four equal phases; tick pulses on
// the last cycle of a phase. stall freezes timing (used for clock stretching).
module i2c_clk_phase_gen
  import i2c_master_pkg::*;
#(
  parameter int DIV = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       stall,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] QTR_LAST = CW'(DIV / 4 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0] cnt_r;
  logic [1:0]    phase_r;

  assign tick  = run && !stall && (cnt_r == QTR_LAST);
  assign phase = phase_r;

  // quarter-period divider and phase index; held cleared while the bus is idle
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_r   <= CNT_ZERO;
      phase_r <= PH_0;
    end else if (stall) begin
      cnt_r   <= cnt_r;
      phase_r <= phase_r;
    end else if (cnt_r == QTR_LAST) begin
      cnt_r   <= CNT_ZERO;
      phase_r <= phase_r + 2'd1;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C write controller: START, address+W, NUM_BYTE data bytes, STOP.
// Define I2C_MASTER_CLK_STRETCH_EN to honour slave clock stretching on SCL.
module i2c_master_ctrl
  import i2c_master_pkg::*;
#(
  parameter int CLK_FREQ     = 50,
  parameter int I2C_CLK_FREQ = 100,
  parameter int NUM_BYTE     = 4,
  parameter int BYTE_SIZE    = 8,
  parameter int DATA_WIDTH   = NUM_BYTE * BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wen,
  input  logic [BYTE_SIZE-2:0]  slave_addr,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  ready,
  output logic                  i2c_slave_addr_err,
  output logic                  i2c_slave_noack_err,
  inout  wire                   i2c_SCL,
  inout  wire                   i2c_SDA
);

  localparam int DIV = CLK_FREQ * 1000 / I2C_CLK_FREQ;
  localparam int BCW = $clog2(BYTE_SIZE);
  localparam int BYW = $clog2(NUM_BYTE + 1);
  localparam logic [BCW-1:0] BIT_ZERO  = BCW'(0);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BYTE_SIZE - 1);
  localparam logic [BYW-1:0] BYTE_ZERO = BYW'(0);
  localparam logic [BYW-1:0] BYTE_ONE  = BYW'(1);
  localparam logic [BYW-1:0] BYTE_LAST = BYW'(NUM_BYTE);

  state_t                state_r, state_next_s;
  logic                  tick_s, stall_s, run_s, period_end_s, accept_s, load_s;
  logic [1:0]            phase_s;
  logic [BYTE_SIZE-1:0]  shift_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [BCW-1:0]        bit_cnt_r;
  logic [BYW-1:0]        byte_cnt_r;
  logic                  nack_r, sda_low_r, scl_low_r, ready_r, addr_err_r, data_err_r;
  logic                  scl_low_s, sda_drive_s;

  assign i2c_SCL             = scl_low_r ? 1'b0 : 1'bz;
  assign i2c_SDA             = sda_low_r ? 1'b0 : 1'bz;
  assign ready               = ready_r;
  assign i2c_slave_addr_err  = addr_err_r;
  assign i2c_slave_noack_err = data_err_r;

  assign run_s        = (state_r != IDLE);
  assign accept_s     = (state_r == IDLE) && req && wen;
  assign period_end_s = tick_s && (phase_s == PH_3);
  assign load_s       = period_end_s && (state_next_s == DATA) && (state_r != DATA);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // a slave holding SCL low while we have released it freezes the bit timing
  assign stall_s = phase_s[1] && !scl_low_r && !i2c_SCL;
`else
  assign stall_s = 1'b0;
`endif

  i2c_clk_phase_gen #(.DIV(DIV)) u_phase_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (run_s),
    .stall (stall_s),
    .tick  (tick_s),
    .phase (phase_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic; every transition except accept happens at a bit-period boundary
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:     if (accept_s) state_next_s = START; else state_next_s = IDLE;
      START:    if (period_end_s) state_next_s = ADDR; else state_next_s = START;
      ADDR:     if (period_end_s && bit_cnt_r == BIT_LAST) state_next_s = ADDR_ACK;
                else state_next_s = ADDR;
      ADDR_ACK: if (!period_end_s) state_next_s = ADDR_ACK;
                else if (nack_r) state_next_s = STOP;
                else state_next_s = DATA;
      DATA:     if (period_end_s && bit_cnt_r == BIT_LAST) state_next_s = DATA_ACK;
                else state_next_s = DATA;
      DATA_ACK: if (!period_end_s) state_next_s = DATA_ACK;
                else if (nack_r || byte_cnt_r == BYTE_LAST) state_next_s = STOP;
                else state_next_s = DATA;
      // second STOP period is the bus-free time
      STOP:     if (period_end_s && bit_cnt_r != BIT_ZERO) state_next_s = IDLE;
                else state_next_s = STOP;
      default:  state_next_s = IDLE;
    endcase
  end

  // line levels wanted for the current state; SDA value is applied at phase-1 entry
  always_comb begin
    scl_low_s   = 1'b0;
    sda_drive_s = 1'b0;
    case (state_r)
      START: begin
        scl_low_s   = 1'b0;
        sda_drive_s = 1'b1;
      end
      ADDR, DATA: begin
        scl_low_s   = (phase_s == PH_0) || (phase_s == PH_1);
        sda_drive_s = !shift_r[BYTE_SIZE-1];
      end
      ADDR_ACK, DATA_ACK: begin
        scl_low_s   = (phase_s == PH_0) || (phase_s == PH_1);
        sda_drive_s = 1'b0;
      end
      STOP: begin
        scl_low_s   = ((phase_s == PH_0) || (phase_s == PH_1)) && (bit_cnt_r == BIT_ZERO);
        sda_drive_s = (bit_cnt_r == BIT_ZERO);
      end
      default: begin
        scl_low_s   = 1'b0;
        sda_drive_s = 1'b0;
      end
    endcase
  end

  // datapath: request latch, shifter, counters, line drivers and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= {BYTE_SIZE{1'b0}};
      data_r     <= {DATA_WIDTH{1'b0}};
      bit_cnt_r  <= BIT_ZERO;
      byte_cnt_r <= BYTE_ZERO;
      nack_r     <= 1'b0;
      sda_low_r  <= 1'b0;
      scl_low_r  <= 1'b0;
      ready_r    <= 1'b1;
      addr_err_r <= 1'b0;
      data_err_r <= 1'b0;
    end else begin
      ready_r   <= (state_next_s == IDLE);
      scl_low_r <= scl_low_s;
      if (accept_s) begin
        shift_r    <= {slave_addr, RW_WRITE};
        data_r     <= writedata;
        byte_cnt_r <= BYTE_ZERO;
        addr_err_r <= 1'b0;
        data_err_r <= 1'b0;
      end else if (load_s) begin
        shift_r    <= data_r[BYTE_SIZE-1:0];
        data_r     <= data_r >> BYTE_SIZE;
        byte_cnt_r <= byte_cnt_r + BYTE_ONE;
      end else if (period_end_s && (state_r == ADDR || state_r == DATA)) begin
        shift_r <= {shift_r[BYTE_SIZE-2:0], 1'b0};
      end
      if (period_end_s) begin
        bit_cnt_r <= (state_next_s == state_r) ? bit_cnt_r + BIT_ONE : BIT_ZERO;
        if (nack_r && state_r == ADDR_ACK) addr_err_r <= 1'b1;
        if (nack_r && state_r == DATA_ACK) data_err_r <= 1'b1;
      end
      if (tick_s && phase_s == PH_0) begin
        sda_low_r <= sda_drive_s;
      end else if (tick_s && phase_s == PH_2 && state_r == STOP) begin
        sda_low_r <= 1'b0;
      end
      // sample SDA as phase 3 begins, mid SCL-high
      if (tick_s && phase_s == PH_2) nack_r <= i2c_SDA;
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench for i2c_master_ctrl: a behavioural I2C slave decodes the bus,
// and a transaction-level model predicts bytes, duration and error flags.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

  localparam int CLK_FREQ     = 8;
  localparam int I2C_CLK_FREQ = 500;
  localparam int NUM_BYTE     = 4;
  localparam int DIV          = CLK_FREQ * 1000 / I2C_CLK_FREQ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic [6:0]  slave_addr = 7'd0;
  logic [31:0] writedata = 32'd0;
  logic        ready, addr_err, noack_err;
  wire         i2c_SCL, i2c_SDA;
  logic        slave_sda_low = 1'b0;

  pullup (i2c_SCL);
  pullup (i2c_SDA);
  assign i2c_SDA = slave_sda_low ? 1'b0 : 1'bz;

  int checks = 0;
  int failures = 0;

  i2c_master_ctrl #(
    .CLK_FREQ(CLK_FREQ), .I2C_CLK_FREQ(I2C_CLK_FREQ), .NUM_BYTE(NUM_BYTE), .BYTE_SIZE(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .slave_addr(slave_addr),
    .writedata(writedata), .ready(ready), .i2c_slave_addr_err(addr_err),
    .i2c_slave_noack_err(noack_err), .i2c_SCL(i2c_SCL), .i2c_SDA(i2c_SDA)
  );

  always #62.5 clk = ~clk;

  // behavioural slave: frame index 0 is the address byte, 1..N the data bytes
  int         nack_at = -1;
  int         s_bitcnt = 0;
  int         s_byteidx = 0;
  bit         s_in_txn = 1'b0;
  logic [7:0] s_cur = 8'd0;
  logic [7:0] rx_q[$];
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;

  always @(negedge clk) begin
    logic scl_v, sda_v;
    scl_v = i2c_SCL;
    sda_v = i2c_SDA;
    if (scl_prev && scl_v && sda_prev && !sda_v) begin
      start_cnt++; s_in_txn = 1'b1; s_bitcnt = 0; s_byteidx = 0; slave_sda_low = 1'b0;
    end else if (scl_prev && scl_v && !sda_prev && sda_v) begin
      stop_cnt++; s_in_txn = 1'b0; slave_sda_low = 1'b0;
    end else if (s_in_txn && !scl_prev && scl_v) begin
      if (s_bitcnt < 8) begin
        s_cur = {s_cur[6:0], sda_v};
        s_bitcnt++;
      end
    end else if (s_in_txn && scl_prev && !scl_v) begin
      if (s_bitcnt == 8) begin
        rx_q.push_back(s_cur);
        slave_sda_low = (s_byteidx != nack_at);
        s_bitcnt = 9;
      end else if (s_bitcnt == 9) begin
        slave_sda_low = 1'b0;
        s_bitcnt = 0;
        s_byteidx++;
      end
    end
    scl_prev = scl_v;
    sda_prev = sda_v;
  end

  // One full request; called on a negedge where ready is expected high.
  task automatic run_txn(input logic [6:0] a, input logic [31:0] d, input int nk,
                         input bit busy_poke, input string name);
    int sent, exp_cycles, low, st0, sp0;
    logic [7:0] exp_q[$];
    bit bad;
    nack_at = nk;
    rx_q.delete();
    st0 = start_cnt;
    sp0 = stop_cnt;
    sent = (nk < 0) ? NUM_BYTE : nk;
    exp_q.push_back({a, 1'b0});
    for (int k = 0; k < sent; k++) exp_q.push_back(d[8*k +: 8]);
    exp_cycles = (1 + 9 * (1 + sent) + 2) * DIV;

    slave_addr = a; writedata = d; wen = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0; wen = 1'b0; slave_addr = 7'($urandom); writedata = $urandom;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL %s accept: ready=%b required 0", name, ready);
    end
    low = 0;
    while (ready !== 1'b1 && low < 60 * DIV) begin
      low++;
      if (busy_poke && low == 5 * DIV) begin
        slave_addr = ~a; writedata = ~d; wen = 1'b1; req = 1'b1;
      end else if (busy_poke && low == 5 * DIV + 1) begin
        req = 1'b0; wen = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (low != exp_cycles) begin
      failures++; $display("FAIL %s busy_cycles: got %0d required %0d", name, low, exp_cycles);
    end
    checks++;
    if (addr_err !== (nk == 0) || noack_err !== (nk >= 1)) begin
      failures++;
      $display("FAIL %s flags: addr_err=%b noack_err=%b required %b %b",
               name, addr_err, noack_err, (nk == 0), (nk >= 1));
    end
    checks++;
    bad = (rx_q.size() != exp_q.size());
    if (!bad) for (int i = 0; i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad) begin
      failures++;
      $display("FAIL %s bytes: got %0d bytes first=%h required %0d bytes first=%h",
               name, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, exp_q.size(), exp_q[0]);
    end
    checks++;
    if (start_cnt - st0 != 1 || stop_cnt - sp0 != 1) begin
      failures++;
      $display("FAIL %s start_stop: starts=%0d stops=%0d required 1 1",
               name, start_cnt - st0, stop_cnt - sp0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || addr_err !== 1'b0 || noack_err !== 1'b0 ||
        i2c_SCL !== 1'b1 || i2c_SDA !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: ready=%b errs=%b%b scl=%b sda=%b required 1 00 1 1",
               ready, addr_err, noack_err, i2c_SCL, i2c_SDA);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_write();
    run_txn(7'h55, 32'hDEADBEEF, -1, 1'b0, "basic_write");
  endtask

  task automatic test_back_to_back();
    run_txn(7'h70, 32'hABCDABCD, -1, 1'b0, "b2b_first");
    run_txn(7'h66, 32'h11111111, -1, 1'b0, "b2b_second");
    repeat (8) @(negedge clk);
    run_txn(7'h66, 32'h11111111, -1, 1'b0, "after_gap");
  endtask

  task automatic test_addr_nack();
    run_txn(7'h2A, 32'h12345678, 0, 1'b0, "addr_nack");
  endtask

  task automatic test_data_nack();
    run_txn(7'h3C, 32'hCAFEF00D, 2, 1'b0, "data_nack_byte1");
  endtask

  task automatic test_ignored();
    int st0;
    bit stayed;
    st0 = start_cnt;
    stayed = 1'b1;
    slave_addr = 7'h11; writedata = 32'h0; wen = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3 * DIV) begin
      if (ready !== 1'b1) stayed = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stayed || start_cnt != st0 || noack_err !== 1'b1) begin
      failures++;
      $display("FAIL wen0_ignored: ready_stayed=%b starts=%0d noack_err=%b required 1 0 1",
               stayed, start_cnt - st0, noack_err);
    end
    run_txn(7'h5A, 32'h0F1E2D3C, -1, 1'b1, "busy_req_ignored");
  endtask

  task automatic test_reset_mid();
    nack_at = -1;
    slave_addr = 7'h44; writedata = 32'h87654321; wen = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0; wen = 1'b0;
    repeat (13 * DIV + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (i2c_SCL !== 1'b1 || i2c_SDA !== 1'b1 || ready !== 1'b1 ||
        addr_err !== 1'b0 || noack_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: scl=%b sda=%b ready=%b errs=%b%b required 1 1 1 00",
               i2c_SCL, i2c_SDA, ready, addr_err, noack_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_txn(7'h44, 32'h87654321, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic [31:0] d;
    int nk;
    for (int i = 0; i < 8; i++) begin
      a = 7'($urandom_range(0, 127));
      d = $urandom;
      nk = ($urandom_range(0, 3) < 2) ? -1 : int'($urandom_range(0, NUM_BYTE));
      run_txn(a, d, nk, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_addr_nack();
    test_data_nack();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(200000 * 125);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-master I2C write controller. Converts a one-cycle parallel request (7-bit slave address + NUM_BYTE data bytes) into an I2C write transaction on open-drain SCL/SDA.
- Sits between a local register/bus interface and the board-level I2C pins, which have external pull-ups.
- Reports address NACK and data NACK as error flags.

Parameters:
- CLK_FREQ, 50, system clock frequency in MHz.
- I2C_CLK_FREQ, 100, SCL frequency in kHz.
- NUM_BYTE, 4, data bytes per transaction.
- BYTE_SIZE, 8, bits per byte.
- DATA_WIDTH, NUM_BYTE*BYTE_SIZE, width of writedata (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  request strobe; sampled only while ready=1
- wen  in  1  1 = write; requests with wen=0 are ignored
- slave_addr  in  BYTE_SIZE-1  7-bit target address
- writedata  in  DATA_WIDTH  payload; byte k is writedata[8k+7:8k]
- ready  out  1  idle and able to accept req
- i2c_slave_addr_err  out  1  sticky: slave NACKed the address byte
- i2c_slave_noack_err  out  1  sticky: slave NACKed a data byte
- i2c_SCL  inout  1  open-drain clock; drives 0 or Z only
- i2c_SDA  inout  1  open-drain data; drives 0 or Z only

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Timing
  - DIV = CLK_FREQ*1000/I2C_CLK_FREQ clk cycles per SCL period (500 at defaults).
  - Each SCL bit period is split into 4 phases of DIV/4 cycles each.
  - SCL is low in phases 0–1 and released in phases 2–3.
  - SDA changes only at the start of phase 1 (SCL low).
  - SDA is sampled at the start of phase 3 (SCL high).
- Reset values: ready=1, both error flags=0, SCL and SDA released (Z), state IDLE, divider cleared.
- Accept
  - When ready=1, req=1 and wen=1, latch slave_addr and writedata and clear both error flags.
  - ready goes to 0 on the next clk edge.
  - req while ready=0, or with wen=0, is ignored with no side effects.
- States: IDLE -> START -> ADDR -> ADDR_ACK -> DATA -> DATA_ACK -> (DATA | STOP) -> IDLE.
- START: SDA falls while SCL is high (one full bit period), then SCL goes low.
- ADDR
  - Shift {slave_addr, 1'b0} MSB first, 8 bits.
  - R/W bit is always 0 (write).
- ADDR_ACK
  - Release SDA for one bit and sample it.
  - Sampled 1 (NACK): set i2c_slave_addr_err and go to STOP.
  - Sampled 0 (ACK): go to DATA.
- DATA
  - Bytes are sent in order byte0 (writedata[7:0]) first through byte NUM_BYTE-1.
  - Bits within a byte go MSB first.
- DATA_ACK
  - NACK: set i2c_slave_noack_err and go to STOP; remaining bytes are abandoned.
  - ACK: advance to the next byte, or go to STOP after the last byte.
- STOP
  - SDA is low while SCL rises; then SDA is released while SCL is high.
  - Hold one bit period of bus-free time, then IDLE.
  - ready=1 on the cycle IDLE is entered.
- Duration: a full 4-byte transaction is 1 + 9 + 36 + 1 + 1 = 48 SCL periods.
- Back-to-back: a new req is accepted on the first cycle ready=1; no minimum gap.
- Error flags stay valid until the next accepted request or reset.
- Reset mid-transaction: both lines are released immediately, state returns to IDLE, flags clear. No STOP is generated.
- Counter widths: $clog2(DIV), $clog2(BYTE_SIZE), $clog2(NUM_BYTE+1). No wrap beyond terminal counts.

Optional Feature:
- Macro I2C_MASTER_CLK_STRETCH_EN.
  - Defined: while the master has released SCL (phases 2–3), the phase counter is frozen whenever the sampled i2c_SCL is 0. This honours slave clock stretching, and timing resumes when SCL reads 1.
  - Undefined: SCL input is never read. Phases advance purely on the divider.

Decomposition:
- Package i2c_master_pkg holds:
  - state enum (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP)
  - phase encoding constants
  - R/W bit constant (WRITE=0)
- One sub-module, i2c_clk_phase_gen: takes DIV, outputs a one-cycle phase-tick strobe plus the 2-bit phase index, and takes a stall input used by the stretch feature.
- The FSM, shift register and byte counter stay in the top module.

Test Plan:
- Write addr 0x55, data 0xDEADBEEF, slave ACKs all bytes:
  - slave receives address 0x55 with R/W=0, bytes EF, BE, AD, DE in that order
  - ready low for 48 SCL periods, both errors stay 0
- Back-to-back writes (addr 0x70, data 0xABCDABCD), then after a 1 µs gap (addr 0x66, data 0x11111111): both are received exactly; the second req is accepted on the first ready cycle.
- Address with no responding slave (SDA pulled high at ACK): i2c_slave_addr_err=1, STOP generated, no data bytes on the bus, ready returns to 1.
- Slave NACKs byte1: i2c_slave_noack_err=1, STOP immediately after the byte1 ACK slot, bytes 2–3 not sent. A following good request clears the flag.
- req pulsed while busy, and req with wen=0 while idle: both ignored, bus and flags unchanged.
- rst asserted mid-DATA: SCL/SDA go to Z the next cycle, ready=1, flags=0; a subsequent request completes correctly.
